r3_input_commutator: RTL and testbench

Input commutator for a radix-3 stage of the radix-6 FFT datapath. It accepts one complex sample per clock in natural order. For each frame of N samples it emits N/3 aligned triplets (x[n], x[n+N/3], x[n+2N/3]) on three parallel complex lanes a/b/c. This is the parallel-lane format the radix-3/radix-2 butterfly stage consumes. The block converts the serial stream into that format, so the butterfly needs no alignment delays of its own.

---
 rtl/r3_input_commutator.sv | 169 ++++++++++++++++
 tb/tb_r3_input_commutator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r3_input_commutator.sv
// r3_input_commutator: serial-to-triplet commutator in front of a radix-3 butterfly.
// Accepts one complex sample per accepted cycle in natural order and, for each
// N-sample frame, emits M = N/3 triplets (x[n], x[n+M], x[n+2M]) on lanes a/b/c.
//
// Optional feature macro: R3C_SOF_SYNC_EN (in_sof resynchronises framing and
// frame_err reports misaligned starts). Undefined: in_sof ignored, frame_err = 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_sof         sample strobe, start-of-frame marker
//   in_re, in_img            input sample words (DW each)
//   out_valid/out_sof/out_last  triplet strobe and frame position flags
//   a_*, b_*, c_*            lanes x[n], x[n+M], x[n+2M]
//   frame_err                one-cycle framing error pulse
module r3_input_commutator #(
  parameter int unsigned N  = 18,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_last,
  output logic [DW-1:0] a_re,
  output logic [DW-1:0] a_img,
  output logic [DW-1:0] b_re,
  output logic [DW-1:0] b_img,
  output logic [DW-1:0] c_re,
  output logic [DW-1:0] c_img,
  output logic          frame_err
);

  localparam int unsigned M  = N / 3;
  localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned SW = 2 * DW;

  typedef enum logic [1:0] {FILL_A, FILL_B, EMIT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_last_q, out_last_d;
  logic          frame_err_q, frame_err_d;
  logic [SW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;

  logic [SW-1:0] buf_a_q [M];
  logic [SW-1:0] buf_b_q [M];

  logic          wr_a_c, wr_b_c;
  logic [IW-1:0] cur_idx_c;
  state_t        cur_state_c;
  logic          err_c;

  // Effective segment position for this sample (a sync sample restarts at FILL_A, 0).
`ifdef R3C_SOF_SYNC_EN
  always_comb begin
    cur_state_c = state_q;
    cur_idx_c   = idx_q;
    err_c       = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        cur_state_c = FILL_A;
        cur_idx_c   = '0;
        err_c       = !((state_q == FILL_A) && (idx_q == '0));
      end else begin
        err_c       = (state_q == FILL_A) && (idx_q == '0);
      end
    end
  end
`else
  logic sof_unused;
  assign sof_unused = in_sof;

  always_comb begin
    cur_state_c = state_q;
    cur_idx_c   = idx_q;
    err_c       = 1'b0;
  end
`endif

  // Next-state, buffer write strobes and output register inputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_sof_d   = out_sof_q;
    out_last_d  = out_last_q;
    frame_err_d = err_c;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    wr_a_c      = 1'b0;
    wr_b_c      = 1'b0;
    if (in_valid) begin
      if (cur_idx_c == IW'(M - 1)) begin
        idx_d = '0;
        case (cur_state_c)
          FILL_A:  state_d = FILL_B;
          FILL_B:  state_d = EMIT;
          default: state_d = FILL_A;
        endcase
      end else begin
        idx_d   = IW'(cur_idx_c + 1'b1);
        state_d = cur_state_c;
      end
      case (cur_state_c)
        FILL_A: wr_a_c = 1'b1;
        FILL_B: wr_b_c = 1'b1;
        default: begin
          out_valid_d = 1'b1;
          out_sof_d   = (cur_idx_c == '0);
          out_last_d  = (cur_idx_c == IW'(M - 1));
          a_d         = buf_a_q[cur_idx_c];
          b_d         = buf_b_q[cur_idx_c];
          c_d         = {in_re, in_img};
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL_A;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
    end
  end

  // Segment buffers; contents need no reset since they are always written before read.
  always_ff @(posedge clk) begin
    if (!rst && wr_a_c) buf_a_q[cur_idx_c] <= {in_re, in_img};
    if (!rst && wr_b_c) buf_b_q[cur_idx_c] <= {in_re, in_img};
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;
  assign a_re      = a_q[SW-1:DW];
  assign a_img     = a_q[DW-1:0];
  assign b_re      = b_q[SW-1:DW];
  assign b_img     = b_q[DW-1:0];
  assign c_re      = c_q[SW-1:DW];
  assign c_img     = c_q[DW-1:0];

endmodule

// File: tb/tb_r3_input_commutator.sv
// Directed bench for r3_input_commutator: N=18 instance plus an N=3 instance.
module tb_r3_input_commutator;
  localparam int unsigned DW = 32;
`ifdef R3C_SOF_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_sof;
  logic [DW-1:0] in_re, in_img;
  logic          out_valid, out_sof, out_last, frame_err;
  logic [DW-1:0] a_re, a_img, b_re, b_img, c_re, c_img;

  logic          in3_valid, in3_sof;
  logic [DW-1:0] in3_re, in3_img;
  logic          out3_valid, out3_sof, out3_last, frame3_err;
  logic [DW-1:0] a3_re, a3_img, b3_re, b3_img, c3_re, c3_img;

  int checks = 0;
  int errors = 0;

  r3_input_commutator #(.N(18), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_img(in_img), .out_valid(out_valid), .out_sof(out_sof),
    .out_last(out_last), .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img),
    .c_re(c_re), .c_img(c_img), .frame_err(frame_err)
  );

  r3_input_commutator #(.N(3), .DW(DW)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_sof(in3_sof),
    .in_re(in3_re), .in_img(in3_img), .out_valid(out3_valid), .out_sof(out3_sof),
    .out_last(out3_last), .a_re(a3_re), .a_img(a3_img), .b_re(b3_re), .b_img(b3_img),
    .c_re(c3_re), .c_img(c3_img), .frame_err(frame3_err)
  );

  function automatic logic [195:0] obs();
    return {out_valid, out_sof, out_last, frame_err, a_re, a_img, b_re, b_img, c_re, c_img};
  endfunction

  function automatic logic [195:0] obs3();
    return {out3_valid, out3_sof, out3_last, frame3_err, a3_re, a3_img, b3_re, b3_img, c3_re, c3_img};
  endfunction

  // Expected output vector; img words are always re + 100.
  function automatic logic [195:0] mk(input logic s, input logic l, input logic e,
                                      input int a, input int b, input int c);
    return {1'b1, s, l, e, 32'(a), 32'(a + 100), 32'(b), 32'(b + 100), 32'(c), 32'(c + 100)};
  endfunction

  task automatic drive(input logic v, input logic s, input int re);
    in_valid = v;
    in_sof   = s;
    in_re    = 32'(re);
    in_img   = 32'(re + 100);
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic v, input logic s, input int re);
    in3_valid = v;
    in3_sof   = s;
    in3_re    = 32'(re);
    in3_img   = 32'(re + 100);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    checks++;
    if (obs() !== 196'd0) begin
      errors++;
      $display("FAIL reset_n18 got %h exp 0", obs());
    end
    checks++;
    if (obs3() !== 196'd0) begin
      errors++;
      $display("FAIL reset_n3 got %h exp 0", obs3());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, k == 0, k);
      checks++;
      if (k >= 12) begin
        if (obs() !== mk(k == 12, k == 17, 1'b0, k - 12, k - 6, k)) begin
          errors++;
          $display("FAIL basic k=%0d got %h exp %h", k, obs(), mk(k == 12, k == 17, 1'b0, k - 12, k - 6, k));
        end
      end else if ({out_valid, frame_err} !== 2'b00) begin
        errors++;
        $display("FAIL basic_idle k=%0d got valid=%b err=%b exp 0 0", k, out_valid, frame_err);
      end
    end
    drive(1'b0, 1'b0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_after got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_gaps();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, k == 0, k);
      if (out_valid === 1'b1) pulses++;
      checks++;
      if (k >= 12) begin
        if (obs() !== mk(k == 12, k == 17, 1'b0, k - 12, k - 6, k)) begin
          errors++;
          $display("FAIL gaps k=%0d got %h exp %h", k, obs(), mk(k == 12, k == 17, 1'b0, k - 12, k - 6, k));
        end
      end else if ({out_valid, frame_err} !== 2'b00) begin
        errors++;
        $display("FAIL gaps_idle k=%0d got valid=%b err=%b exp 0 0", k, out_valid, frame_err);
      end
      drive(1'b0, 1'b0, 999);
      if (out_valid === 1'b1) pulses++;
      checks++;
      if ({out_valid, frame_err} !== 2'b00) begin
        errors++;
        $display("FAIL gaps_gap k=%0d got valid=%b err=%b exp 0 0", k, out_valid, frame_err);
      end
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL gaps_pulses got %0d exp 6", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    for (int f = 0; f < 3; f++) begin
      base = 1000 * (f + 1);
      for (int k = 0; k < 18; k++) begin
        drive(1'b1, k == 0, base + k);
        checks++;
        if (k >= 12) begin
          if (obs() !== mk(k == 12, k == 17, 1'b0, base + k - 12, base + k - 6, base + k)) begin
            errors++;
            $display("FAIL b2b f=%0d k=%0d got %h exp %h", f, k, obs(),
                     mk(k == 12, k == 17, 1'b0, base + k - 12, base + k - 6, base + k));
          end
        end else if ({out_valid, frame_err} !== 2'b00) begin
          errors++;
          $display("FAIL b2b_idle f=%0d k=%0d got valid=%b err=%b exp 0 0", f, k, out_valid, frame_err);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, k == 0, 200 + k);
      checks++;
      if ({out_valid, frame_err} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_pre k=%0d got valid=%b err=%b exp 0 0", k, out_valid, frame_err);
      end
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 999);
    rst = 1'b0;
    checks++;
    if (obs() !== 196'd0) begin
      errors++;
      $display("FAIL rstmid_zero got %h exp 0", obs());
    end
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, k == 0, 50 + k);
      checks++;
      if (k >= 12) begin
        if (obs() !== mk(k == 12, k == 17, 1'b0, 38 + k, 44 + k, 50 + k)) begin
          errors++;
          $display("FAIL rstmid k=%0d got %h exp %h", k, obs(), mk(k == 12, k == 17, 1'b0, 38 + k, 44 + k, 50 + k));
        end
      end else if ({out_valid, frame_err} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_idle k=%0d got valid=%b err=%b exp 0 0", k, out_valid, frame_err);
      end
    end
    in_valid = 1'b0;
  endtask

  // in_sof on stream sample 7: resync restarts the frame there, otherwise framing stays positional.
  task automatic test_sof();
    int v [25];
    int start, p;
    logic exp_err;
    logic [195:0] exp_v;
    for (int k = 0; k < 25; k++) v[k] = (k < 7) ? 300 + k : 493 + k;
    for (int k = 0; k < 25; k++) begin
      drive(1'b1, (k == 0) || (k == 7), v[k]);
      if (SYNC) start = (k >= 7) ? 7 : 0;
      else      start = (k >= 18) ? 18 : 0;
      p       = k - start;
      exp_err = SYNC && (k == 7);
      checks++;
      if (p >= 12) begin
        exp_v = mk(p == 12, p == 17, exp_err, v[k - 12], v[k - 6], v[k]);
        if (obs() !== exp_v) begin
          errors++;
          $display("FAIL sof k=%0d got %h exp %h", k, obs(), exp_v);
        end
      end else if ({out_valid, frame_err} !== {1'b0, exp_err}) begin
        errors++;
        $display("FAIL sof_idle k=%0d got valid=%b err=%b exp 0 %b", k, out_valid, frame_err, exp_err);
      end
    end
    drive(1'b0, 1'b0, 0);
    checks++;
    if ({out_valid, frame_err} !== 2'b00) begin
      errors++;
      $display("FAIL sof_after got valid=%b err=%b exp 0 0", out_valid, frame_err);
    end
  endtask

  task automatic test_n3();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive3(1'b1, (k == 1) || (k == 4), k);
      checks++;
      if (k % 3 == 0) begin
        if (obs3() !== mk(1'b1, 1'b1, 1'b0, k - 2, k - 1, k)) begin
          errors++;
          $display("FAIL n3 k=%0d got %h exp %h", k, obs3(), mk(1'b1, 1'b1, 1'b0, k - 2, k - 1, k));
        end
      end else if ({out3_valid, frame3_err} !== 2'b00) begin
        errors++;
        $display("FAIL n3_idle k=%0d got valid=%b err=%b exp 0 0", k, out3_valid, frame3_err);
      end
    end
    drive3(1'b0, 1'b0, 0);
    checks++;
    if (out3_valid !== 1'b0) begin
      errors++;
      $display("FAIL n3_after got valid=%b exp 0", out3_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_re     = '0;
    in_img    = '0;
    in3_valid = 1'b0;
    in3_sof   = 1'b0;
    in3_re    = '0;
    in3_img   = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_sof();
    test_n3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
